// File: rtl/timing_sequencer.sv
// Phase / bit-time / syllable sequencer with free-run, drain-to-boundary and single-step control.
// Defining TIMING_TMR_EN triplicates the state store with 2-of-3 voting and a sticky tmr_err flag.
module timing_sequencer #(
    parameter int PHASES    = 3,
    parameter int BIT_TIMES = 14,
    parameter int SYLLABLES = 2,
    parameter int BW        = $clog2(BIT_TIMES),
    parameter int SW        = (SYLLABLES > 1) ? $clog2(SYLLABLES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step_req,
    input  logic                 resync,
    output logic [PHASES-1:0]    phase,
    output logic [PHASES-1:0]    phase_n,
    output logic [BW-1:0]        bit_num,
    output logic [BIT_TIMES-1:0] bit_onehot,
    output logic [SW-1:0]        syl,
    output logic [SW-1:0]        syl_n,
    output logic                 tbc,
    output logic                 word_end,
    output logic                 running,
    output logic                 tmr_err
);

    localparam int PW = $clog2(PHASES);

    localparam logic [PW-1:0] PH_LAST  = PW'(PHASES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_TIMES - 1);
    localparam logic [SW-1:0] SYL_LAST = SW'(SYLLABLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STEP  = 2'd3
    } fsm_e;

    typedef struct packed {
        fsm_e            fsm;
        logic [PW-1:0]   phase;
        logic [BW-1:0]   bit_n;
        logic [SW-1:0]   syl;
        logic            resync_pend;
    } state_t;

    localparam state_t ST_RESET = '{fsm: IDLE, phase: '0, bit_n: '0, syl: '0, resync_pend: 1'b0};

    state_t cur;
    state_t st_d;
    logic   advance;
    logic   pend_eff;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        st_d     = cur;
        advance  = 1'b0;
        pend_eff = cur.resync_pend | resync;

        case (cur.fsm)
            IDLE: begin
                if (run) begin
                    st_d.fsm = RUN;
                end else if (step_req) begin
                    st_d.fsm = STEP;
                end
            end
            RUN: begin
                advance = 1'b1;
                if (!run) begin
                    st_d.fsm = (cur.phase == PH_LAST) ? IDLE : DRAIN;
                end
            end
            DRAIN, STEP: begin
                advance = 1'b1;
                if (run) begin
                    st_d.fsm = RUN;
                end else if (cur.phase == PH_LAST) begin
                    st_d.fsm = IDLE;
                end
            end
            default: st_d.fsm = IDLE;
        endcase

        st_d.resync_pend = pend_eff;

        // A pending resync replaces the normal carry at the bit-time wrap.
        if (advance) begin
            if (cur.phase == PH_LAST) begin
                st_d.phase = '0;
                if (pend_eff) begin
                    st_d.bit_n       = '0;
                    st_d.syl         = '0;
                    st_d.resync_pend = 1'b0;
                end else if (cur.bit_n == BIT_LAST) begin
                    st_d.bit_n = '0;
                    st_d.syl   = (cur.syl == SYL_LAST) ? '0 : cur.syl + 1'b1;
                end else begin
                    st_d.bit_n = cur.bit_n + 1'b1;
                end
            end else begin
                st_d.phase = cur.phase + 1'b1;
            end
        end
    end

`ifdef TIMING_TMR_EN
    localparam int ST_W = $bits(state_t);

    state_t          st_a_q;
    state_t          st_b_q;
    state_t          st_c_q;
    logic [ST_W-1:0] va;
    logic [ST_W-1:0] vb;
    logic [ST_W-1:0] vc;
    logic            disagree;
    logic            tmr_err_d;
    logic            tmr_err_q;

    always_comb begin
        va        = st_a_q;
        vb        = st_b_q;
        vc        = st_c_q;
        cur       = state_t'((va & vb) | (va & vc) | (vb & vc));
        disagree  = (va != vb) || (va != vc);
        tmr_err_d = tmr_err_q | disagree;
    end

    // Each copy is rewritten from the voted next state, so a single upset scrubs itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_a_q    <= ST_RESET;
            st_b_q    <= ST_RESET;
            st_c_q    <= ST_RESET;
            tmr_err_q <= 1'b0;
        end else begin
            st_a_q    <= st_d;
            st_b_q    <= st_d;
            st_c_q    <= st_d;
            tmr_err_q <= tmr_err_d;
        end
    end

    assign tmr_err = tmr_err_q;
`else
    state_t st_q;

    assign cur = st_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_RESET;
        end else begin
            st_q <= st_d;
        end
    end

    assign tmr_err = 1'b0;
`endif

    assign running    = (cur.fsm != IDLE);
    assign phase      = running ? (PHASES'(1) << cur.phase) : '0;
    assign phase_n    = ~phase;
    assign bit_num    = cur.bit_n;
    assign bit_onehot = running ? (BIT_TIMES'(1) << cur.bit_n) : '0;
    assign syl        = cur.syl;
    assign syl_n      = ~cur.syl;
    assign tbc        = running && (cur.phase == PH_LAST) && (cur.bit_n == BIT_LAST);
    assign word_end   = tbc && (cur.syl == SYL_LAST);

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer at default parameters (3 phases, 14 bit times, 2 syllables).
// Compile with TIMING_TMR_EN defined to also exercise the triplicated state store.
module tb_timing_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step_req;
    logic        resync;
    logic [2:0]  phase;
    logic [2:0]  phase_n;
    logic [3:0]  bit_num;
    logic [13:0] bit_onehot;
    logic [0:0]  syl;
    logic [0:0]  syl_n;
    logic        tbc;
    logic        word_end;
    logic        running;
    logic        tmr_err;

    int n_cmp;
    int n_fail;

    // {phase, bit_num, syl, tbc, word_end, running}
    logic [10:0] obs_v;
    logic [10:0] exp_v;
    assign obs_v = {phase, bit_num, syl, tbc, word_end, running};

    timing_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step_req   (step_req),
        .resync     (resync),
        .phase      (phase),
        .phase_n    (phase_n),
        .bit_num    (bit_num),
        .bit_onehot (bit_onehot),
        .syl        (syl),
        .syl_n      (syl_n),
        .tbc        (tbc),
        .word_end   (word_end),
        .running    (running),
        .tmr_err    (tmr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp_vec(input string name);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got ph=%b bit=%0d syl=%0d tbc=%b we=%b run=%b, want ph=%b bit=%0d syl=%0d tbc=%b we=%b run=%b",
                     name, obs_v[10:8], obs_v[7:4], obs_v[3], obs_v[2], obs_v[1], obs_v[0],
                     exp_v[10:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b0; step_req = 1'b0; resync = 1'b0;
        repeat (2) @(negedge clk);
        exp_v = {3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        cmp_vec("reset_outputs");
        n_cmp++;
        if (phase_n !== 3'b111) begin n_fail++; $display("FAIL reset_phase_n: got %b want 111", phase_n); end
        n_cmp++;
        if (bit_onehot !== 14'd0) begin n_fail++; $display("FAIL reset_bit_onehot: got %h want 0", bit_onehot); end
        n_cmp++;
        if (tmr_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmr_err: got %b want 0", tmr_err); end
    endtask

    task automatic test_free_run;
        int tbc_cnt;
        int we_cnt;
        int we_at;
        tbc_cnt = 0; we_cnt = 0; we_at = 0;
        reset = 1'b0; run = 1'b1;
        for (int c = 1; c <= 84; c++) begin
            @(negedge clk);
            if (tbc === 1'b1) tbc_cnt++;
            if (word_end === 1'b1) begin we_cnt++; we_at = c; end
            if (c == 1) begin
                exp_v = {3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
                cmp_vec("run_first_cycle");
                n_cmp++;
                if (bit_onehot !== 14'h0001) begin n_fail++; $display("FAIL run_onehot_b0: got %h want 0001", bit_onehot); end
            end
            if (c == 4) begin
                exp_v = {3'b001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
                cmp_vec("run_bit1_after_3");
            end
            if (c == 42) begin
                exp_v = {3'b100, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1};
                cmp_vec("run_tbc_cycle42");
                n_cmp++;
                if (bit_onehot !== 14'h2000) begin n_fail++; $display("FAIL run_onehot_b13: got %h want 2000", bit_onehot); end
            end
            if (c == 43) begin
                exp_v = {3'b001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
                cmp_vec("run_syl1_start");
                n_cmp++;
                if (syl_n !== 1'b0) begin n_fail++; $display("FAIL run_syl_n: got %b want 0", syl_n); end
            end
            if (c == 84) begin
                exp_v = {3'b100, 4'd13, 1'b1, 1'b1, 1'b1, 1'b1};
                cmp_vec("run_word_end_cycle84");
            end
        end
        n_cmp++;
        if (tbc_cnt != 2) begin n_fail++; $display("FAIL run_tbc_count: got %0d want 2", tbc_cnt); end
        n_cmp++;
        if (we_cnt != 1 || we_at != 84) begin
            n_fail++; $display("FAIL run_word_end_count: got %0d at %0d want 1 at 84", we_cnt, we_at);
        end
        @(negedge clk);
        exp_v = {3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("run_period_84");
    endtask

    task automatic test_stop;
        repeat (15) @(negedge clk);
        exp_v = {3'b001, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("stop_at_bit5_ph0");
        run = 1'b0;
        @(negedge clk);
        exp_v = {3'b010, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("stop_drain_ph1");
        @(negedge clk);
        exp_v = {3'b100, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("stop_drain_ph2");
        @(negedge clk);
        exp_v = {3'b000, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        cmp_vec("stop_idle_bit6");
        n_cmp++;
        if (phase_n !== 3'b111 || bit_onehot !== 14'd0) begin
            n_fail++; $display("FAIL stop_idle_decodes: got phase_n=%b onehot=%h want 111 0000", phase_n, bit_onehot);
        end
        @(negedge clk);
        cmp_vec("stop_idle_holds");
    endtask

    task automatic test_step;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        exp_v = {3'b001, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("step_ph0");
        @(negedge clk);
        exp_v = {3'b010, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("step_ph1");
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        exp_v = {3'b100, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("step_ph2");
        @(negedge clk);
        exp_v = {3'b000, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        cmp_vec("step_idle_bit7");
        @(negedge clk);
        cmp_vec("step_second_req_ignored");
    endtask

    task automatic test_restart;
        run = 1'b1;
        @(negedge clk);
        exp_v = {3'b001, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("restart_resumes_bit7");
        run = 1'b0;
        @(negedge clk);
        exp_v = {3'b010, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("restart_drain_ph1");
        run = 1'b1;
        @(negedge clk);
        exp_v = {3'b100, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("restart_drain_to_run");
        @(negedge clk);
        exp_v = {3'b001, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("restart_no_gap");
    endtask

    task automatic test_resync;
        int tbc_cnt;
        tbc_cnt = 0;
        repeat (46) @(negedge clk);
        exp_v = {3'b010, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1};
        cmp_vec("resync_pre_bit9_syl1");
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        exp_v = {3'b100, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1};
        cmp_vec("resync_pending_ph2");
        @(negedge clk);
        exp_v = {3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("resync_bit0_syl0");
        for (int k = 2; k <= 42; k++) begin
            @(negedge clk);
            if (k < 42 && tbc === 1'b1) tbc_cnt++;
            if (k == 42) begin
                exp_v = {3'b100, 4'd13, 1'b0, 1'b1, 1'b0, 1'b1};
                cmp_vec("resync_next_tbc");
            end
        end
        n_cmp++;
        if (tbc_cnt != 0) begin n_fail++; $display("FAIL resync_early_tbc: got %0d want 0", tbc_cnt); end
    endtask

    task automatic test_reset_mid;
        repeat (29) @(negedge clk);
        exp_v = {3'b010, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1};
        cmp_vec("mid_pre_reset");
        reset = 1'b1; resync = 1'b1;
        @(negedge clk);
        exp_v = {3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        cmp_vec("mid_reset_outputs");
        n_cmp++;
        if (phase_n !== 3'b111 || bit_onehot !== 14'd0 || tmr_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_decodes: got phase_n=%b onehot=%h tmr=%b want 111 0000 0",
                               phase_n, bit_onehot, tmr_err);
        end
        reset = 1'b0; resync = 1'b0;
        @(negedge clk);
        exp_v = {3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("mid_restart_bit0");
        repeat (3) @(negedge clk);
        exp_v = {3'b001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("mid_resync_dropped");
    endtask

    task automatic test_tmr;
`ifdef TIMING_TMR_EN
        force dut.st_b_q = dut.st_a_q ^ 10'd4;
        @(negedge clk);
        release dut.st_b_q;
        exp_v = {3'b010, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("tmr_outputs_masked");
        n_cmp++;
        if (tmr_err !== 1'b1) begin n_fail++; $display("FAIL tmr_err_set: got %b want 1", tmr_err); end
        repeat (4) @(negedge clk);
        exp_v = {3'b100, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        cmp_vec("tmr_scrubbed_run");
        n_cmp++;
        if (tmr_err !== 1'b1) begin n_fail++; $display("FAIL tmr_err_sticky: got %b want 1", tmr_err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (tmr_err !== 1'b0) begin n_fail++; $display("FAIL tmr_err_cleared: got %b want 0", tmr_err); end
`else
        @(negedge clk);
        n_cmp++;
        if (tmr_err !== 1'b0) begin n_fail++; $display("FAIL tmr_err_tied: got %b want 0", tmr_err); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1; run = 1'b0; step_req = 1'b0; resync = 1'b0;
        exp_v = '0;
        test_reset;
        test_free_run;
        test_stop;
        test_step;
        test_restart;
        test_resync;
        test_reset_mid;
        test_tmr;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
